// File: rtl/lc3_mem_responder_if.sv
// LC-3 level-strobe memory bus between the datapath controller (master) and
// the memory responder (slave).
//   Mem_OE, Mem_WE  : level read/write strobes, held for the whole access
//   ADDR            : word address (MAR)
//   Data_from_CPU   : write data (MDR)
//   Data_to_CPU     : registered read data
//   Mem_Ready       : access complete while the strobe is still high
interface lc3_mem_responder_if;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;
  logic        Mem_Ready;

  modport master (
    output Mem_OE, Mem_WE, ADDR, Data_from_CPU,
    input  Data_to_CPU, Mem_Ready
  );

  modport slave (
    input  Mem_OE, Mem_WE, ADDR, Data_from_CPU,
    output Data_to_CPU, Mem_Ready
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 level-strobe memory interface.
// Serves reads and writes from an on-chip word array or a single
// memory-mapped I/O address (Switches on read, HEX_Out on write).
// Ports:
//   Clk      : sole clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : slave side of the strobe bus (OE/WE, ADDR, data, Mem_Ready)
//   Switches : board switches, returned on reads of IO_ADDR
//   HEX_Out  : register written by stores to IO_ADDR
//   Busy     : high whenever the FSM is not idle
//   Err      : sticky protocol-error flag, cleared only by reset
module lc3_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          READ_LAT  = 3,
  parameter int          WRITE_LAT = 4,
  parameter logic [15:0] IO_ADDR   = 16'hFFFF
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  lc3_mem_responder_if.slave         bus,
  input  logic [15:0]                Switches,
  output logic [15:0]                HEX_Out,
  output logic                       Busy,
  output logic                       Err
);

  localparam int AW      = $clog2(DEPTH);
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  // cnt holds the number of edges already seen; the action edge is the one
  // where the running count reaches the latency, i.e. cnt == LAT-1 before it.
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_LAT - 1);
  localparam logic [15:0]      DEPTH_W = 16'(DEPTH);

  typedef enum logic [2:0] {IDLE, RD, RD_HOLD, WR, WR_HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ready_q, ready_nxt;
  logic             err_q, err_set;
  logic             latch, rd_load, wr_commit;
  logic [15:0]      data_q, hex_q;
  logic [15:0]      addr_q, wdata_q;
  logic [15:0]      eff_addr, eff_data, rd_val;
  logic             is_io, in_range;
  logic [AW-1:0]    idx;
  logic [15:0]      mem [DEPTH];

  // With a latency of 1 the access completes on the detect edge itself, so
  // the live bus values are used while still in IDLE.
  assign eff_addr = (state == IDLE) ? bus.ADDR          : addr_q;
  assign eff_data = (state == IDLE) ? bus.Data_from_CPU : wdata_q;
  assign is_io    = (eff_addr == IO_ADDR);
  assign in_range = (eff_addr < DEPTH_W);
  assign idx      = eff_addr[AW-1:0];

  always_comb begin
    rd_val = 16'h0000;
    if (is_io)         rd_val = Switches;
    else if (in_range) rd_val = mem[idx];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 16'h0000;
      hex_q   <= 16'h0000;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= ready_nxt;
      err_q   <= err_q | err_set;
      if (rd_load)            data_q <= rd_val;
      if (wr_commit && is_io) hex_q  <= eff_data;
    end
  end

  // Address/data captured at detect; later bus changes are ignored.
  always_ff @(posedge Clk) begin
    if (latch) begin
      addr_q  <= bus.ADDR;
      wdata_q <= bus.Data_from_CPU;
    end
  end

  // Single write port; out-of-range and I/O stores never touch the array.
  always_ff @(posedge Clk) begin
    if (wr_commit && in_range && !is_io) mem[idx] <= eff_data;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = ready_q;
    err_set   = 1'b0;
    latch     = 1'b0;
    rd_load   = 1'b0;
    wr_commit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Mem_OE && bus.Mem_WE) begin
          err_set = 1'b1;
        end else if (bus.Mem_OE) begin
          latch   = 1'b1;
          cnt_nxt = CNT_W'(1);
          if (READ_LAT == 1) begin
            rd_load   = 1'b1;
            ready_nxt = 1'b1;
            state_nxt = RD_HOLD;
          end else begin
            state_nxt = RD;
          end
        end else if (bus.Mem_WE) begin
          latch   = 1'b1;
          cnt_nxt = CNT_W'(1);
          if (WRITE_LAT == 1) begin
            wr_commit = 1'b1;
            ready_nxt = 1'b1;
            state_nxt = WR_HOLD;
          end else begin
            state_nxt = WR;
          end
        end
      end
      RD: begin
        if (bus.Mem_WE) err_set = 1'b1;
        if (!bus.Mem_OE) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == RD_LAST) begin
          rd_load   = 1'b1;
          ready_nxt = 1'b1;
          state_nxt = RD_HOLD;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RD_HOLD: begin
        if (bus.Mem_WE) err_set = 1'b1;
        if (!bus.Mem_OE) begin
          ready_nxt = 1'b0;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      WR: begin
        if (bus.Mem_OE) err_set = 1'b1;
        if (!bus.Mem_WE) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == WR_LAST) begin
          wr_commit = 1'b1;
          ready_nxt = 1'b1;
          state_nxt = WR_HOLD;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WR_HOLD: begin
        if (bus.Mem_OE) err_set = 1'b1;
        if (!bus.Mem_WE) begin
          ready_nxt = 1'b0;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        ready_nxt = 1'b0;
      end
    endcase
  end

  assign bus.Data_to_CPU = data_q;
  assign bus.Mem_Ready   = ready_q;
  assign HEX_Out         = hex_q;
  assign Busy            = (state != IDLE);
  assign Err             = err_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder with default latencies (3/4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_lc3_mem_responder;
  localparam int DEPTH = 1024;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] Switches = 16'h0000;
  logic [15:0] HEX_Out;
  logic        Busy;
  logic        Err;

  lc3_mem_responder_if bus();

  lc3_mem_responder #(
    .DEPTH(DEPTH), .READ_LAT(3), .WRITE_LAT(4), .IO_ADDR(16'hFFFF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus), .Switches(Switches),
    .HEX_Out(HEX_Out), .Busy(Busy), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // OE held for exactly 4 cycles; ADDR is scrambled after detect.
  task automatic rd_access(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.ADDR = a; bus.Mem_OE = 1'b1;
    @(negedge Clk); bus.ADDR = a ^ 16'h0155;
    @(negedge Clk); check_val({tag, "_rdy_early"}, 16'(bus.Mem_Ready), 16'd0);
    @(negedge Clk); check_val({tag, "_data"}, bus.Data_to_CPU, exp);
                    check_val({tag, "_rdy"}, 16'(bus.Mem_Ready), 16'd1);
    @(negedge Clk); check_val({tag, "_rdy_hold"}, 16'(bus.Mem_Ready), 16'd1);
    bus.Mem_OE = 1'b0;
    @(negedge Clk); check_val({tag, "_rdy_off"}, 16'(bus.Mem_Ready), 16'd0);
                    check_val({tag, "_busy_off"}, 16'(Busy), 16'd0);
  endtask

  // WE held for n cycles; write data is scrambled after detect.
  task automatic wr_access(input string tag, input logic [15:0] a, input logic [15:0] d,
                           input int n, input logic exp_rdy);
    bus.ADDR = a; bus.Data_from_CPU = d; bus.Mem_WE = 1'b1;
    @(negedge Clk); bus.Data_from_CPU = ~d;
    repeat (n - 1) @(negedge Clk);
    check_val({tag, "_rdy_end"}, 16'(bus.Mem_Ready), 16'(exp_rdy));
    bus.Mem_WE = 1'b0; bus.ADDR = 16'h0000; bus.Data_from_CPU = 16'h0000;
    @(negedge Clk); check_val({tag, "_rdy_off"}, 16'(bus.Mem_Ready), 16'd0);
                    check_val({tag, "_busy_off"}, 16'(Busy), 16'd0);
  endtask

  task automatic pulse_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0;
    bus.ADDR = 16'h0000; bus.Data_from_CPU = 16'h0000;
    @(negedge Clk);
    pulse_reset();
    check_val("rst_data", bus.Data_to_CPU, 16'h0000);
    check_val("rst_rdy", 16'(bus.Mem_Ready), 16'd0);
    check_val("rst_hex", HEX_Out, 16'h0000);
    check_val("rst_busy", 16'(Busy), 16'd0);
    check_val("rst_err", 16'(Err), 16'd0);

    // Preload and read back
    wr_access("wr_beef", 16'h0010, 16'hBEEF, 4, 1'b1);
    rd_access("rd_beef", 16'h0010, 16'hBEEF);

    // Reset in the middle of a read
    bus.ADDR = 16'h0010; bus.Mem_OE = 1'b1;
    repeat (2) @(negedge Clk);
    check_val("midrd_busy", 16'(Busy), 16'd1);
    #2 Reset_n = 1'b0;
    #1 check_val("midrd_async_busy", 16'(Busy), 16'd0);
    check_val("midrd_async_data", bus.Data_to_CPU, 16'h0000);
    bus.Mem_OE = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;
    @(negedge Clk);
    check_val("midrd_rel_data", bus.Data_to_CPU, 16'h0000);
    check_val("midrd_rel_rdy", 16'(bus.Mem_Ready), 16'd0);
    check_val("midrd_rel_busy", 16'(Busy), 16'd0);
    check_val("midrd_rel_err", 16'(Err), 16'd0);

    // Write then read, aborted write, re-read
    wr_access("wr_1234", 16'h0020, 16'h1234, 4, 1'b1);
    rd_access("rd_1234", 16'h0020, 16'h1234);
    wr_access("wr_abort", 16'h0020, 16'hFFFF, 2, 1'b0);
    rd_access("rd_after_abort", 16'h0020, 16'h1234);

    // MMIO read and write
    Switches = 16'h00A5;
    rd_access("rd_sw", 16'hFFFF, 16'h00A5);
    bus.ADDR = 16'hFFFF; bus.Data_from_CPU = 16'h0042; bus.Mem_WE = 1'b1;
    repeat (3) @(negedge Clk);
    check_val("hex_before_commit", HEX_Out, 16'h0000);
    @(negedge Clk);
    check_val("hex_commit", HEX_Out, 16'h0042);
    check_val("hex_rdy", 16'(bus.Mem_Ready), 16'd1);
    bus.Mem_WE = 1'b0;
    @(negedge Clk);
    check_val("hex_busy_off", 16'(Busy), 16'd0);

    // Out of range: no aliasing onto word 5
    wr_access("wr_w5", 16'h0005, 16'h5555, 4, 1'b1);
    wr_access("wr_oor", 16'(DEPTH + 5), 16'hAAAA, 4, 1'b1);
    rd_access("rd_oor", 16'(DEPTH + 5), 16'h0000);
    rd_access("rd_w5", 16'h0005, 16'h5555);
    check_val("err_clean", 16'(Err), 16'd0);

    // Both strobes at once: error, no access
    bus.ADDR = 16'h0020; bus.Data_from_CPU = 16'h9999;
    bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b1;
    @(negedge Clk);
    check_val("both_err", 16'(Err), 16'd1);
    check_val("both_busy", 16'(Busy), 16'd0);
    bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0;
    repeat (3) @(negedge Clk);
    check_val("both_data_kept", bus.Data_to_CPU, 16'h5555);
    check_val("both_hex_kept", HEX_Out, 16'h0042);
    check_val("both_err_sticky", 16'(Err), 16'd1);
    rd_access("rd_after_both", 16'h0020, 16'h1234);
    pulse_reset();
    check_val("err_cleared", 16'(Err), 16'd0);

    // WE raised during RD_HOLD
    bus.ADDR = 16'h0010; bus.Mem_OE = 1'b1;
    repeat (3) @(negedge Clk);
    check_val("x_data", bus.Data_to_CPU, 16'hBEEF);
    check_val("x_err_before", 16'(Err), 16'd0);
    bus.Mem_WE = 1'b1;
    @(negedge Clk);
    check_val("x_err", 16'(Err), 16'd1);
    check_val("x_data_hold", bus.Data_to_CPU, 16'hBEEF);
    check_val("x_rdy_hold", 16'(bus.Mem_Ready), 16'd1);
    bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0;
    @(negedge Clk);
    check_val("x_rdy_off", 16'(bus.Mem_Ready), 16'd0);
    check_val("x_busy_off", 16'(Busy), 16'd0);
    check_val("x_data_after", bus.Data_to_CPU, 16'hBEEF);
    repeat (3) @(negedge Clk);
    check_val("x_err_sticky", 16'(Err), 16'd1);
    pulse_reset();
    check_val("x_err_reset", 16'(Err), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
